// File: rtl/pic_pkg.sv
// Shared definitions for the interrupt-controller sequencing core:
// FSM state encoding, request-line count, spurious level and vector fields.
package pic_pkg;

  localparam int NUM_IR       = 8;
  localparam int SPURIOUS_LVL = 7;
  localparam int LVL_W        = 3;
  localparam int BASE_W       = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    ACK1 = 2'd2,
    ACK2 = 2'd3
  } pic_state_t;

endpackage

// File: rtl/pic_priority_resolver.sv
// Combinational priority resolver. Scans req in priority order and returns
// the first request that is strictly higher priority than every in-service
// level in isr. With isr tied to zero it simply finds the highest-priority
// set bit of req, which is how the EOI target is found.
// Optional macro PIC_ROTATE_PRIORITY_EN: scan starts at (ptr+1) mod 8
// instead of at level 0.
module pic_priority_resolver
  import pic_pkg::*;
(
  input  logic [NUM_IR-1:0] req,
  input  logic [NUM_IR-1:0] isr,
`ifdef PIC_ROTATE_PRIORITY_EN
  input  logic [LVL_W-1:0]  ptr,
`endif
  output logic              valid,
  output logic [LVL_W-1:0]  idx
);

  logic [LVL_W-1:0] start;
  logic [LVL_W-1:0] pos;
  logic             done;

  // Walk levels from highest to lowest priority; an in-service level stops the scan
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    done  = 1'b0;
    pos   = '0;
`ifdef PIC_ROTATE_PRIORITY_EN
    start = LVL_W'(ptr + LVL_W'(1));
`else
    start = '0;
`endif
    for (int i = 0; i < NUM_IR; i++) begin
      pos = LVL_W'(start + LVL_W'(i));
      if (!done) begin
        if (isr[pos]) begin
          done = 1'b1;
        end else if (req[pos]) begin
          valid = 1'b1;
          idx   = pos;
          done  = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/pic_ack_sequencer.sv
// Interrupt controller sequencing core: edge-latched IRR, IMR masking,
// priority resolution against ISR, int_o generation, two-pulse INTA
// handshake delivering {base, lvl}, and non-specific EOI retirement.
// Optional macro PIC_ROTATE_PRIORITY_EN: rotating priority, where each EOI
// makes the level it retired the lowest priority.
module pic_ack_sequencer
  import pic_pkg::*;
#(
  parameter int NUM_IR       = pic_pkg::NUM_IR,
  parameter int SPURIOUS_LVL = pic_pkg::SPURIOUS_LVL
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_IR-1:0] ir,
  input  logic              inta_n,
  input  logic              imr_wr,
  input  logic              base_wr,
  input  logic [7:0]        cfg_data,
  input  logic              eoi,
  output logic              int_o,
  output logic [7:0]        vec_out,
  output logic              vec_oe,
  output logic [NUM_IR-1:0] irr_o,
  output logic [NUM_IR-1:0] isr_o
);

  pic_state_t        state, state_d;
  logic [NUM_IR-1:0] ir_q;
  logic              inta_q;
  logic [NUM_IR-1:0] irr, isr, imr;
  logic [BASE_W-1:0] base;
  logic [LVL_W-1:0]  lvl;
  logic              int_r;
  logic [7:0]        vec_r;
  logic              vec_oe_r;

  logic [NUM_IR-1:0] rise;
  logic              fall;
  logic              commit;
  logic              load_vec;
  logic              cand_valid, eoi_valid;
  logic [LVL_W-1:0]  cand_idx, eoi_idx;
  logic [NUM_IR-1:0] isr_set, irr_clr, isr_clr;

`ifdef PIC_ROTATE_PRIORITY_EN
  logic [LVL_W-1:0]  ptr;
`endif

  assign rise = ir & ~ir_q;
  assign fall = inta_q & ~inta_n;

  // Candidate: highest-priority unmasked request above all in-service levels
  pic_priority_resolver u_cand (
    .req   (irr & ~imr),
    .isr   (isr),
`ifdef PIC_ROTATE_PRIORITY_EN
    .ptr   (ptr),
`endif
    .valid (cand_valid),
    .idx   (cand_idx)
  );

  // EOI target: highest-priority in-service level (nothing blocks it)
  pic_priority_resolver u_eoi (
    .req   (isr),
    .isr   ({NUM_IR{1'b0}}),
`ifdef PIC_ROTATE_PRIORITY_EN
    .ptr   (ptr),
`endif
    .valid (eoi_valid),
    .idx   (eoi_idx)
  );

  // Handshake FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  // Handshake FSM next state and per-cycle strobes
  always_comb begin
    state_d  = state;
    commit   = 1'b0;
    load_vec = 1'b0;
    case (state)
      IDLE: if (cand_valid) state_d = REQ;
      REQ: begin
        if (fall) begin
          commit  = 1'b1;
          state_d = ACK1;
        end
      end
      ACK1: begin
        if (fall) begin
          load_vec = 1'b1;
          state_d  = ACK2;
        end
      end
      ACK2:    if (inta_n) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // One-hot set/clear masks; a spurious acknowledge touches neither IRR nor ISR
  always_comb begin
    isr_set = '0;
    irr_clr = '0;
    isr_clr = '0;
    if (commit && cand_valid) begin
      isr_set[cand_idx] = 1'b1;
      irr_clr[cand_idx] = 1'b1;
    end
    if (eoi && eoi_valid) isr_clr[eoi_idx] = 1'b1;
  end

  // Input edge detectors and request/in-service registers (sets win over clears)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ir_q   <= '0;
      inta_q <= 1'b1;
      irr    <= '0;
      isr    <= '0;
    end else begin
      ir_q   <= ir;
      inta_q <= inta_n;
      irr    <= (irr & ~irr_clr) | rise;
      isr    <= (isr & ~isr_clr) | isr_set;
    end
  end

  // Configuration registers written from the data bus
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      imr  <= '1;
      base <= '0;
    end else begin
      if (imr_wr)  imr  <= cfg_data;
      if (base_wr) base <= cfg_data[7:3];
    end
  end

  // Frozen level, vector and registered handshake outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lvl      <= '0;
      vec_r    <= '0;
      int_r    <= 1'b0;
      vec_oe_r <= 1'b0;
    end else begin
      if (commit)   lvl   <= cand_valid ? cand_idx : LVL_W'(SPURIOUS_LVL);
      if (load_vec) vec_r <= {base, lvl};
      int_r    <= (state_d == REQ);
      vec_oe_r <= (state_d == ACK2);
    end
  end

`ifdef PIC_ROTATE_PRIORITY_EN
  // Rotation pointer: the level just retired becomes lowest priority
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                   ptr <= LVL_W'(7);
    else if (eoi && eoi_valid) ptr <= eoi_idx;
  end
`endif

  assign int_o   = int_r;
  assign vec_out = vec_r;
  assign vec_oe  = vec_oe_r;
  assign irr_o   = irr;
  assign isr_o   = isr;

endmodule

// File: tb/tb_pic_ack_sequencer.sv
// Directed self-checking bench for pic_ack_sequencer. Inputs change 1 ns
// after each rising edge; outputs are sampled at the same point.
module tb_pic_ack_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] ir;
  logic       inta_n;
  logic       imr_wr;
  logic       base_wr;
  logic [7:0] cfg_data;
  logic       eoi;
  logic       int_o;
  logic [7:0] vec_out;
  logic       vec_oe;
  logic [7:0] irr_o;
  logic [7:0] isr_o;

  int checks = 0;
  int errors = 0;

  pic_ack_sequencer dut (
    .clk      (clk),
    .rst      (rst),
    .ir       (ir),
    .inta_n   (inta_n),
    .imr_wr   (imr_wr),
    .base_wr  (base_wr),
    .cfg_data (cfg_data),
    .eoi      (eoi),
    .int_o    (int_o),
    .vec_out  (vec_out),
    .vec_oe   (vec_oe),
    .irr_o    (irr_o),
    .isr_o    (isr_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; ir = '0; inta_n = 1'b1; imr_wr = 1'b0; base_wr = 1'b0;
    cfg_data = '0; eoi = 1'b0;
    tick(); tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic wr_imr(input logic [7:0] v);
    cfg_data = v; imr_wr = 1'b1; tick(); imr_wr = 1'b0;
  endtask

  task automatic wr_base(input logic [4:0] b);
    cfg_data = {b, 3'b000}; base_wr = 1'b1; tick(); base_wr = 1'b0;
  endtask

  task automatic pulse_ir(input logic [7:0] v);
    ir = v; tick(); ir = '0; tick();
  endtask

  task automatic do_eoi();
    eoi = 1'b1; tick(); eoi = 1'b0;
  endtask

  task automatic wait_int(input string tag);
    for (int i = 0; i < 10 && !int_o; i++) tick();
    chk(tag, int_o, 1);
  endtask

  task automatic ack1(input string tag);
    inta_n = 1'b0; tick();
    chk({tag, "_int_drop"}, int_o, 0);
    inta_n = 1'b1; tick();
  endtask

  task automatic ack2(input string tag, input logic [7:0] exp_vec);
    inta_n = 1'b0; tick();
    chk({tag, "_oe_on"}, vec_oe, 1);
    chk({tag, "_vec"}, vec_out, exp_vec);
    inta_n = 1'b1; tick();
    chk({tag, "_oe_off"}, vec_oe, 0);
  endtask

  task automatic ack_seq(input string tag, input logic [7:0] exp_vec);
    ack1(tag);
    ack2(tag, exp_vec);
  endtask

  initial begin
    do_reset();
    chk("rst_irr", irr_o, 8'h00);
    chk("rst_isr", isr_o, 8'h00);
    chk("rst_int", int_o, 0);
    chk("rst_oe", vec_oe, 0);
    chk("rst_vec", vec_out, 8'h00);
    // IMR resets to all-masked: a request must not raise int_o
    pulse_ir(8'h01); tick();
    chk("rst_masked_int", int_o, 0);
    chk("rst_masked_irr", irr_o, 8'h01);

    // Unmask and single request on IR2
    do_reset();
    wr_imr(8'hF0); wr_base(5'h10);
    ir = 8'h04; tick();
    chk("t1_irr", irr_o, 8'h04);
    chk("t1_int_lat", int_o, 0);
    ir = 8'h00; tick();
    chk("t1_int", int_o, 1);
    inta_n = 1'b0; tick();
    chk("t1_isr", isr_o, 8'h04);
    chk("t1_irr_clr", irr_o, 8'h00);
    chk("t1_int_drop", int_o, 0);
    chk("t1_oe_p1", vec_oe, 0);
    inta_n = 1'b1; tick();
    chk("t1_oe_gap", vec_oe, 0);
    ack2("t1", 8'h82);
    chk("t1_vec_hold", vec_out, 8'h82);

    // Simultaneous IR5 and IR1
    do_reset();
    wr_imr(8'h00); wr_base(5'h10);
    ir = 8'h22; tick();
    chk("t2_irr", irr_o, 8'h22);
    ir = 8'h00; tick();
    wait_int("t2_int_a");
    ack_seq("t2a", 8'h81);
    chk("t2_isr_a", isr_o, 8'h02);
    chk("t2_irr_a", irr_o, 8'h20);
    chk("t2_blocked", int_o, 0);
    do_eoi();
    chk("t2_isr_eoi", isr_o, 8'h00);
    wait_int("t2_int_b");
    ack_seq("t2b", 8'h85);
    chk("t2_isr_b", isr_o, 8'h20);

    // Nesting: IR4 in service, IR6 blocked, IR0 preempts
    do_reset();
    wr_imr(8'h00); wr_base(5'h10);
    pulse_ir(8'h10);
    wait_int("t3_int4");
    ack_seq("t3_4", 8'h84);
    chk("t3_isr4", isr_o, 8'h10);
    pulse_ir(8'h40); tick(); tick();
    chk("t3_int6_blocked", int_o, 0);
    chk("t3_irr6", irr_o, 8'h40);
    pulse_ir(8'h01);
    wait_int("t3_int0");
    ack_seq("t3_0", 8'h80);
    chk("t3_isr_nest", isr_o, 8'h11);
    do_eoi();
    chk("t3_isr_eoi1", isr_o, 8'h10);
    do_eoi();
    chk("t3_isr_eoi2", isr_o, 8'h00);
    wait_int("t3_int6");
    ack_seq("t3_6", 8'h86);
    chk("t3_isr6", isr_o, 8'h40);

    // Spurious: request withdrawn by masking before first INTA
    do_reset();
    wr_imr(8'h00); wr_base(5'h10);
    pulse_ir(8'h08);
    wait_int("t4_int");
    wr_imr(8'h08);
    ack_seq("t4", 8'h87);
    chk("t4_isr", isr_o, 8'h00);
    chk("t4_irr", irr_o, 8'h08);
    tick();
    chk("t4_int_idle", int_o, 0);

    // EOI in the same cycle as a commit: the new bit survives, IR4 retires
    do_reset();
    wr_imr(8'h00); wr_base(5'h10);
    pulse_ir(8'h10);
    wait_int("t5_int4");
    ack_seq("t5_4", 8'h84);
    pulse_ir(8'h01);
    wait_int("t5_int0");
    inta_n = 1'b0; eoi = 1'b1; tick();
    eoi = 1'b0;
    chk("t5_isr_setwins", isr_o, 8'h01);
    inta_n = 1'b1; tick();
    ack2("t5_0", 8'h80);

    // Asynchronous reset between the two INTA pulses
    do_reset();
    wr_imr(8'h00); wr_base(5'h10);
    pulse_ir(8'h04);
    wait_int("t6_int");
    ack1("t6");
    chk("t6_isr_pre", isr_o, 8'h04);
    rst = 1'b1; #1;
    chk("t6_int_rst", int_o, 0);
    chk("t6_oe_rst", vec_oe, 0);
    chk("t6_isr_rst", isr_o, 8'h00);
    chk("t6_irr_rst", irr_o, 8'h00);
    tick();
    rst = 1'b0; tick();
    inta_n = 1'b0; tick();
    chk("t6_ignored_oe", vec_oe, 0);
    inta_n = 1'b1; tick();
    chk("t6_ignored_oe2", vec_oe, 0);
    pulse_ir(8'h02); tick();
    chk("t6_imr_ff", int_o, 0);
    chk("t6_irr_masked", irr_o, 8'h02);

    // Asynchronous reset while the vector is on the bus
    do_reset();
    wr_imr(8'h00); wr_base(5'h10);
    pulse_ir(8'h08);
    wait_int("t7_int");
    ack1("t7");
    inta_n = 1'b0; tick();
    chk("t7_oe_on", vec_oe, 1);
    rst = 1'b1; #1;
    chk("t7_oe_rst", vec_oe, 0);
    chk("t7_vec_rst", vec_out, 8'h00);
    inta_n = 1'b1; tick();
    rst = 1'b0; tick();

`ifdef PIC_ROTATE_PRIORITY_EN
    // Rotation: after servicing IR0, IR4 outranks IR0
    do_reset();
    wr_imr(8'h00); wr_base(5'h10);
    pulse_ir(8'h01);
    wait_int("t8_int0");
    ack_seq("t8_0", 8'h80);
    do_eoi();
    chk("t8_isr_eoi", isr_o, 8'h00);
    pulse_ir(8'h11);
    wait_int("t8_int");
    ack_seq("t8_rot", 8'h84);
    chk("t8_isr", isr_o, 8'h10);
    chk("t8_irr", irr_o, 8'h01);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
